// File: rtl/rgmii_pkg.sv
// Shared RGMII/UDP types, constants and byte-order helpers for the RX and TX paths.
// Header bytes sit at [8k+:8] in wire order, so multi-byte fields need a byte swap.
package rgmii_pkg;

  localparam int          HEADER_BYTES     = 42;
  localparam logic [15:0] UDP_HEADER_BYTES = 16'd8;
  localparam logic [7:0]  PREAMBLE_VAL     = 8'h55;
  localparam logic [7:0]  SFD_VAL          = 8'hD5;
  localparam logic [31:0] CRC32_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    TRAILER,
    DROP
  } rgmii_rx_state_t;

  // Declared last-received-first so that mac_destination byte 0 lands in bits [7:0].
  typedef struct packed {
    logic [15:0] udp_checksum;
    logic [15:0] udp_length;
    logic [15:0] port_destination;
    logic [15:0] port_source;
    logic [31:0] ip_destination;
    logic [31:0] ip_source;
    logic [15:0] ip_checksum;
    logic [7:0]  protocol;
    logic [7:0]  ttl;
    logic [15:0] flags_fragment;
    logic [15:0] identification;
    logic [15:0] total_length;
    logic [7:0]  tos;
    logic [7:0]  version_ihl;
    logic [15:0] eth_type_length;
    logic [47:0] mac_source;
    logic [47:0] mac_destination;
  } ethernet_header_t;

  typedef struct packed {
    logic [5:0][7:0] fpga;
  } rgmii_mac_cfg_t;

  typedef struct packed {
    logic [31:0] fpga;
  } rgmii_ip_cfg_t;

  typedef struct packed {
    logic [15:0] fpga;
  } rgmii_port_cfg_t;

  typedef struct packed {
    logic check_destination;
    logic reset;
  } rgmii_control_t;

  typedef struct packed {
    rgmii_mac_cfg_t  mac;
    rgmii_ip_cfg_t   ip;
    rgmii_port_cfg_t port;
    rgmii_control_t  control;
  } rgmii_config_t;

  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [47:0] swap48(input logic [47:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 single-byte update (no init/final xor), shared by RX and TX.
// Purely combinational; no handshake.
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
  end

  assign crc_o = c;

endmodule

// File: rtl/rgmii_udp_rx.sv
// GMII byte stream -> UDP payload stream; 1-cycle latency, no backpressure (no tready).
// Optional FCS checking with macro RGMII_RX_CRC_EN; without it crc_err_o is tied 0.
module rgmii_udp_rx
  import rgmii_pkg::*;
#(
  parameter int unsigned CHECK_ETH_TYPE = 1
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          rx_dv_i,
  input  logic [7:0]    rx_data_i,
  input  rgmii_config_t cfg_i,
  output logic [7:0]    m_axis_tdata_o,
  output logic          m_axis_tvalid_o,
  output logic          m_axis_tlast_o,
  output logic          m_axis_tuser_o,
  output logic          crc_err_o,
  output logic [15:0]   frame_cnt_o
);

  localparam logic [5:0] HDR_LAST = 6'(HEADER_BYTES - 1);

  rgmii_rx_state_t  state_q, state_d;
  ethernet_header_t hdr_q, hdr_d, hdr_w;
  logic [5:0]       hdr_cnt_q, hdr_cnt_d;
  logic [15:0]      pay_cnt_q, pay_cnt_d;
  logic [15:0]      last_idx_q, last_idx_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic [15:0]      udp_len;
  logic             eth_ok, dst_ok, hdr_ok;

  // Header as it will look once the current byte is written, so the accept
  // decision on the last header byte sees the complete header.
  always_comb begin
    hdr_w = hdr_q;
    hdr_w[8*hdr_cnt_q +: 8] = rx_data_i;
  end

  always_comb begin
    udp_len = swap16(hdr_w.udp_length);
    eth_ok  = (CHECK_ETH_TYPE == 0) || (swap16(hdr_w.eth_type_length) == 16'h0800);
    dst_ok  = !cfg_i.control.check_destination ||
              ((swap48(hdr_w.mac_destination) == cfg_i.mac.fpga) &&
               (swap32(hdr_w.ip_destination) == cfg_i.ip.fpga) &&
               (swap16(hdr_w.port_destination) == cfg_i.port.fpga));
    hdr_ok  = (hdr_w.version_ihl == 8'h45) && (hdr_w.protocol == 8'h11) &&
              eth_ok && dst_ok && (udp_len > UDP_HEADER_BYTES);
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    last_idx_d  = last_idx_q;
    tdata_d     = 8'h00;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (rx_dv_i) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (!rx_dv_i) begin
          state_d = IDLE;
        end else if (rx_data_i == SFD_VAL) begin
          state_d   = HEADER;
          hdr_cnt_d = '0;
        end else if (rx_data_i != PREAMBLE_VAL) begin
          state_d = DROP;
        end
      end
      HEADER: begin
        if (!rx_dv_i) begin
          state_d = IDLE;
        end else begin
          hdr_d     = hdr_w;
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q == HDR_LAST) begin
            pay_cnt_d  = '0;
            last_idx_d = udp_len - UDP_HEADER_BYTES - 16'd1;
            state_d    = hdr_ok ? PAYLOAD : DROP;
          end
        end
      end
      PAYLOAD: begin
        tvalid_d = 1'b1;
        if (!rx_dv_i) begin
          // Truncated frame: a single zero beat flagged bad closes the packet.
          tlast_d = 1'b1;
          tuser_d = 1'b1;
          state_d = IDLE;
        end else begin
          tdata_d   = rx_data_i;
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (pay_cnt_q == last_idx_q) begin
            tlast_d = 1'b1;
            state_d = TRAILER;
          end
        end
      end
      TRAILER, DROP: begin
        if (!rx_dv_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tvalid_d && tlast_d && !tuser_d) frame_cnt_d = frame_cnt_q + 16'd1;

    if (cfg_i.control.reset) begin
      state_d     = IDLE;
      tdata_d     = 8'h00;
      tvalid_d    = 1'b0;
      tlast_d     = 1'b0;
      tuser_d     = 1'b0;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      hdr_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      last_idx_q  <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      last_idx_q  <= last_idx_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tuser_o  = tuser_q;
  assign frame_cnt_o     = frame_cnt_q;

`ifdef RGMII_RX_CRC_EN
  logic [31:0] crc_q, crc_d, crc_upd;
  logic        crc_on_q, crc_on_d;
  logic        crc_err_q, crc_err_d;

  crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (rx_data_i),
    .crc_o  (crc_upd)
  );

  // crc_on tracks "SFD seen, rx_dv not yet fallen"; the residue is judged on the fall.
  always_comb begin
    crc_d     = crc_q;
    crc_on_d  = crc_on_q;
    crc_err_d = crc_err_q;
    if (state_q == PREAMBLE && rx_dv_i && rx_data_i == SFD_VAL) begin
      crc_d    = '1;
      crc_on_d = 1'b1;
    end else if (crc_on_q && rx_dv_i) begin
      crc_d = crc_upd;
    end else if (crc_on_q && !rx_dv_i) begin
      crc_on_d = 1'b0;
      if (crc_q != CRC32_RESIDUE) crc_err_d = 1'b1;
    end
    if (cfg_i.control.reset) begin
      crc_d     = '1;
      crc_on_d  = 1'b0;
      crc_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      crc_q     <= '1;
      crc_on_q  <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_on_q  <= crc_on_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err_o = crc_err_q;
`else
  assign crc_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_udp_rx.sv
// Directed frames for rgmii_udp_rx; expected beats are queued at stimulus time and
// checked by an independent output monitor.
module tb_rgmii_udp_rx;
  import rgmii_pkg::*;

`ifdef RGMII_RX_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          rx_dv_i;
  logic [7:0]    rx_data_i;
  rgmii_config_t cfg_i;
  logic [7:0]    m_axis_tdata_o;
  logic          m_axis_tvalid_o;
  logic          m_axis_tlast_o;
  logic          m_axis_tuser_o;
  logic          crc_err_o;
  logic [15:0]   frame_cnt_o;

  always #5 clk_i = ~clk_i;

  rgmii_udp_rx dut (
    .clk_i           (clk_i),
    .arstn_i         (arstn_i),
    .rx_dv_i         (rx_dv_i),
    .rx_data_i       (rx_data_i),
    .cfg_i           (cfg_i),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tuser_o  (m_axis_tuser_o),
    .crc_err_o       (crc_err_o),
    .frame_cnt_o     (frame_cnt_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         failures = 0;
  int         beats_seen = 0;
  int         beats_exp = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk_i);
      if (m_axis_tvalid_o) begin
        beats_seen++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got data=%02h last=%0d user=%0d, none expected",
                   m_axis_tdata_o, m_axis_tlast_o, m_axis_tuser_o);
        end else begin
          e = sb.pop_front();
          if ({m_axis_tdata_o, m_axis_tlast_o, m_axis_tuser_o} !== e) begin
            failures++;
            $display("FAIL beat: got data=%02h last=%0d user=%0d expected data=%02h last=%0d user=%0d",
                     m_axis_tdata_o, m_axis_tlast_o, m_axis_tuser_o, e.d, e.l, e.u);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < frm.size(); i++) begin
      c ^= {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic build(input logic [15:0] eth_type, input logic [15:0] port_dst,
                       input logic [15:0] udp_len, input int n_pay, input logic [7:0] seed);
    frm.delete();
    push_be(48'h021122334455, 6);
    push_be(48'h020000000001, 6);
    push_be(eth_type, 2);
    push_be(8'h45, 1);
    push_be(8'h00, 1);
    push_be(16'd20 + udp_len, 2);
    push_be(16'h0000, 2);
    push_be(16'h4000, 2);
    push_be(8'h40, 1);
    push_be(8'h11, 1);
    push_be(16'h0000, 2);
    push_be(32'hC0A80101, 4);
    push_be(32'hC0A80102, 4);
    push_be(16'h5000, 2);
    push_be(port_dst, 2);
    push_be(udp_len, 2);
    push_be(16'h0000, 2);
    for (int i = 0; i < n_pay; i++) frm.push_back(seed + 8'(i));
    while (frm.size() < 60) frm.push_back(8'h00);
    add_fcs();
  endtask

  task automatic expect_pay(input int n, input logic [7:0] seed, input logic last_on_end);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = seed + 8'(i);
      b.l = last_on_end && (i == n - 1);
      b.u = 1'b0;
      sb.push_back(b);
      beats_exp++;
    end
  endtask

  task automatic send(input int lim, input logic rst_cut);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      rx_dv_i   = 1'b1;
      rx_data_i = (i == 7) ? SFD_VAL : PREAMBLE_VAL;
    end
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_i);
      rx_data_i = frm[i];
    end
    @(negedge clk_i);
    if (rst_cut) begin
      #2;
      arstn_i = 1'b0;
      rx_dv_i = 1'b0;
      rx_data_i = 8'h00;
      #1;
      check("rst_tvalid", m_axis_tvalid_o, 1'b0);
      check("rst_tdata", m_axis_tdata_o, 8'h00);
      check("rst_tlast", m_axis_tlast_o, 1'b0);
      check("rst_tuser", m_axis_tuser_o, 1'b0);
      check("rst_frame_cnt", frame_cnt_o, 16'd0);
      repeat (3) @(negedge clk_i);
      arstn_i = 1'b1;
    end else begin
      rx_dv_i   = 1'b0;
      rx_data_i = 8'h00;
    end
    repeat (12) @(negedge clk_i);
  endtask

  task automatic ctrl_reset();
    @(negedge clk_i);
    cfg_i.control.reset = 1'b1;
    repeat (2) @(negedge clk_i);
    cfg_i.control.reset = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin : stim
    beat_t b;
    arstn_i   = 1'b0;
    rx_dv_i   = 1'b0;
    rx_data_i = 8'h00;
    cfg_i     = '0;
    cfg_i.mac.fpga = 48'h021122334455;
    cfg_i.ip.fpga  = 32'hC0A80102;
    cfg_i.port.fpga = 16'h1234;
    cfg_i.control.check_destination = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_tvalid", m_axis_tvalid_o, 1'b0);
    check("reset_tdata", m_axis_tdata_o, 8'h00);
    check("reset_tlast", m_axis_tlast_o, 1'b0);
    check("reset_tuser", m_axis_tuser_o, 1'b0);
    check("reset_frame_cnt", frame_cnt_o, 16'd0);
    check("reset_crc_err", crc_err_o, 1'b0);
    check("reset_state", dut.state_q, IDLE);
    check("reset_hdr_zero", (dut.hdr_q == '0), 1'b1);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Good frame, 8 payload bytes.
    build(16'h0800, 16'h1234, 16'd16, 8, 8'hA0);
    expect_pay(8, 8'hA0, 1'b1);
    send(frm.size(), 1'b0);
    check("good_frame_cnt", frame_cnt_o, 16'd1);
    check("good_crc_err", crc_err_o, 1'b0);

    // Destination port mismatch is dropped.
    build(16'h0800, 16'h1235, 16'd16, 8, 8'hB0);
    send(frm.size(), 1'b0);
    check("port_mismatch_frame_cnt", frame_cnt_o, 16'd1);
    check("port_mismatch_beats", beats_seen, 8);

    // Short payload with padding: padding never reaches the stream.
    build(16'h0800, 16'h1234, 16'd12, 4, 8'hC0);
    expect_pay(4, 8'hC0, 1'b1);
    send(frm.size(), 1'b0);
    check("padded_frame_cnt", frame_cnt_o, 16'd2);
    check("padded_state_idle", dut.state_q, IDLE);

    // Non-IPv4 ethertype and udp.length of exactly 8 are both rejected.
    build(16'h86DD, 16'h1234, 16'd16, 8, 8'h50);
    send(frm.size(), 1'b0);
    check("ethtype_frame_cnt", frame_cnt_o, 16'd2);
    build(16'h0800, 16'h1234, 16'd8, 0, 8'h60);
    send(frm.size(), 1'b0);
    check("udp_len8_frame_cnt", frame_cnt_o, 16'd2);

    // rx_dv falls after 3 of 10 payload bytes.
    build(16'h0800, 16'h1234, 16'd18, 10, 8'hD0);
    expect_pay(3, 8'hD0, 1'b0);
    b.d = 8'h00; b.l = 1'b1; b.u = 1'b1;
    sb.push_back(b);
    beats_exp++;
    send(HEADER_BYTES + 3, 1'b0);
    check("trunc_frame_cnt", frame_cnt_o, 16'd2);
    ctrl_reset();
    check("ctrl_reset_frame_cnt", frame_cnt_o, 16'd0);
    check("ctrl_reset_crc_err", crc_err_o, 1'b0);

    // Corrupted FCS: payload still delivered, error flag only with CRC enabled.
    build(16'h0800, 16'h1234, 16'd16, 8, 8'hE0);
    frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
    expect_pay(8, 8'hE0, 1'b1);
    send(frm.size(), 1'b0);
    check("fcs_flip_frame_cnt", frame_cnt_o, 16'd1);
    check("fcs_flip_crc_err", crc_err_o, CRC_ON);
    ctrl_reset();
    check("fcs_clear_crc_err", crc_err_o, 1'b0);
    check("fcs_clear_frame_cnt", frame_cnt_o, 16'd0);

    // Destination checking disabled: mismatching port is accepted.
    cfg_i.control.check_destination = 1'b0;
    build(16'h0800, 16'h1235, 16'd16, 8, 8'h70);
    expect_pay(8, 8'h70, 1'b1);
    send(frm.size(), 1'b0);
    check("nocheck_frame_cnt", frame_cnt_o, 16'd1);
    cfg_i.control.check_destination = 1'b1;

    // Async reset mid-payload, then a clean frame.
    build(16'h0800, 16'h1234, 16'd18, 10, 8'hF0);
    expect_pay(4, 8'hF0, 1'b0);
    send(HEADER_BYTES + 4, 1'b1);
    check("after_rst_state", dut.state_q, IDLE);
    build(16'h0800, 16'h1234, 16'd16, 8, 8'h11);
    expect_pay(8, 8'h11, 1'b1);
    send(frm.size(), 1'b0);
    check("after_rst_frame_cnt", frame_cnt_o, 16'd1);
    check("after_rst_crc_err", crc_err_o, 1'b0);

    check("sb_empty", sb.size(), 0);
    check("total_beats", beats_seen, beats_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
